// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: response codes and small sizing helpers.
package axil_pkg;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t AXIL_RESP_OKAY   = 2'b00;
  localparam axil_resp_t AXIL_RESP_SLVERR = 2'b10;
  localparam axil_resp_t AXIL_RESP_DECERR = 2'b11;

  // Width of a register index; a single register still needs one bit.
  function automatic int axil_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axil_addr_index.sv
// Combinational decode of a byte address into a register index plus an
// in-range flag. Byte-offset bits below the word size are ignored.
module axil_addr_index
  import axil_pkg::*;
#(
  parameter int NUMBER_REGS    = 8,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET = AXI_ADDR_WIDTH'(32'h4000_0000),
  localparam int IDX_W = axil_idx_width(NUMBER_REGS)
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]          idx,
  output logic                      in_range
);

  localparam int BYTE_SHIFT = $clog2(AXI_DATA_WIDTH / 8);
  localparam logic [AXI_ADDR_WIDTH-1:0] NREGS_A = AXI_ADDR_WIDTH'(NUMBER_REGS);

  logic [AXI_ADDR_WIDTH-1:0] delta;
  logic [AXI_ADDR_WIDTH-1:0] word;

  // Subtract the base, drop byte-offset bits, and range-check the word index.
  always_comb begin
    delta    = addr - AXI_ADDR_OFFSET;
    word     = delta >> BYTE_SHIFT;
    in_range = (addr >= AXI_ADDR_OFFSET) && (word < NREGS_A);
    idx      = word[IDX_W-1:0];
  end

endmodule

// File: rtl/axil_slave_regs.sv
// AXI-Lite register bank responder. Writes collect AW and W independently
// into hold registers and commit once both are held and no B is pending.
// Reads are registered with one-cycle latency. Read-only registers return
// fabric-supplied values and reject writes with SLVERR.
module axil_slave_regs
  import axil_pkg::*;
#(
  parameter int NUMBER_REGS    = 8,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET = AXI_ADDR_WIDTH'(32'h4000_0000),
  parameter logic [NUMBER_REGS-1:0]    REG_RO_MASK     = NUMBER_REGS'(8'h80)
) (
  input  logic                                  aclk,
  input  logic                                  areset,
  input  logic [AXI_ADDR_WIDTH-1:0]             s_axil_awaddr,
  input  logic                                  s_axil_awvalid,
  output logic                                  s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]             s_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]           s_axil_wstrb,
  input  logic                                  s_axil_wvalid,
  output logic                                  s_axil_wready,
  output logic [1:0]                            s_axil_bresp,
  output logic                                  s_axil_bvalid,
  input  logic                                  s_axil_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]             s_axil_araddr,
  input  logic                                  s_axil_arvalid,
  output logic                                  s_axil_arready,
  output logic [AXI_DATA_WIDTH-1:0]             s_axil_rdata,
  output logic [1:0]                            s_axil_rresp,
  output logic                                  s_axil_rvalid,
  input  logic                                  s_axil_rready,
  output logic [NUMBER_REGS*AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUMBER_REGS*AXI_DATA_WIDTH-1:0] reg_in,
  output logic [NUMBER_REGS-1:0]                wr_pulse
);

  localparam int IDX_W  = axil_idx_width(NUMBER_REGS);
  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  // Register storage and write-path hold state
  logic [NUMBER_REGS-1:0][AXI_DATA_WIDTH-1:0] regs_q, regs_d;
  logic                      aw_held_q, aw_held_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                      w_held_q, w_held_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic                      bvalid_q, bvalid_d;
  axil_resp_t                bresp_q, bresp_d;
  logic [NUMBER_REGS-1:0]    wr_pulse_q, wr_pulse_d;

  // Read-path state
  logic                      rvalid_q, rvalid_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  axil_resp_t                rresp_q, rresp_d;

  // Decode results
  logic [IDX_W-1:0] aw_idx, ar_idx;
  logic             aw_in_range, ar_in_range;
  logic             aw_ro, ar_ro;
  logic             commit, commit_ok;
  logic             aw_hs, w_hs, ar_hs;
  logic [AXI_DATA_WIDTH-1:0] rd_val;

  axil_addr_index #(
    .NUMBER_REGS     (NUMBER_REGS),
    .AXI_DATA_WIDTH  (AXI_DATA_WIDTH),
    .AXI_ADDR_WIDTH  (AXI_ADDR_WIDTH),
    .AXI_ADDR_OFFSET (AXI_ADDR_OFFSET)
  ) u_aw_index (
    .addr     (awaddr_q),
    .idx      (aw_idx),
    .in_range (aw_in_range)
  );

  axil_addr_index #(
    .NUMBER_REGS     (NUMBER_REGS),
    .AXI_DATA_WIDTH  (AXI_DATA_WIDTH),
    .AXI_ADDR_WIDTH  (AXI_ADDR_WIDTH),
    .AXI_ADDR_OFFSET (AXI_ADDR_OFFSET)
  ) u_ar_index (
    .addr     (s_axil_araddr),
    .idx      (ar_idx),
    .in_range (ar_in_range)
  );

  // Ready signals are held low during reset so nothing is accepted then.
  assign s_axil_awready = !aw_held_q && !areset;
  assign s_axil_wready  = !w_held_q  && !areset;
  assign s_axil_arready = !rvalid_q  && !areset;

  assign aw_hs = s_axil_awvalid && s_axil_awready;
  assign w_hs  = s_axil_wvalid  && s_axil_wready;
  assign ar_hs = s_axil_arvalid && s_axil_arready;

  assign commit = aw_held_q && w_held_q && !bvalid_q;

  // Look up read-only status and read value by index; out-of-range indices
  // match nothing, which the in-range flags cover.
  always_comb begin
    aw_ro  = 1'b0;
    ar_ro  = 1'b0;
    rd_val = '0;
    for (int r = 0; r < NUMBER_REGS; r++) begin
      if (aw_idx == IDX_W'(r)) begin
        aw_ro = REG_RO_MASK[r];
      end
      if (ar_idx == IDX_W'(r)) begin
        ar_ro  = REG_RO_MASK[r];
        rd_val = REG_RO_MASK[r] ? reg_in[r*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] : regs_q[r];
      end
    end
  end

  assign commit_ok = commit && aw_in_range && !aw_ro;

  // Write path: capture AW/W payloads, commit byte lanes, and drive B.
  always_comb begin
    aw_held_d  = aw_held_q;
    awaddr_d   = awaddr_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axil_awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axil_wdata;
      wstrb_d  = s_axil_wstrb;
    end

    if (bvalid_q && s_axil_bready) begin
      bvalid_d = 1'b0;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = commit_ok ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
      for (int r = 0; r < NUMBER_REGS; r++) begin
        if (commit_ok && (aw_idx == IDX_W'(r))) begin
          wr_pulse_d[r] = 1'b1;
          for (int b = 0; b < STRB_W; b++) begin
            if (wstrb_q[b]) begin
              regs_d[r][b*8 +: 8] = wdata_q[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Read path: register data/response on AR handshake, hold until R completes.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && s_axil_rready) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      if (ar_in_range) begin
        rdata_d = rd_val;
        rresp_d = AXIL_RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = AXIL_RESP_SLVERR;
      end
    end
  end

  // State registers; reset drops any in-flight transaction.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      regs_q     <= '0;
      aw_held_q  <= 1'b0;
      awaddr_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= AXIL_RESP_OKAY;
      wr_pulse_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= AXIL_RESP_OKAY;
    end else begin
      regs_q     <= regs_d;
      aw_held_q  <= aw_held_d;
      awaddr_q   <= awaddr_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // Read-only slices are tied to zero on the fabric side.
  for (genvar g = 0; g < NUMBER_REGS; g++) begin : g_reg_out
    assign reg_out[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = REG_RO_MASK[g] ? '0 : regs_q[g];
  end

  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp  = bresp_q;
  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rdata  = rdata_q;
  assign s_axil_rresp  = rresp_q;
  assign wr_pulse      = wr_pulse_q;

endmodule

// File: tb/tb_axil_slave_regs.sv
// Directed bench for axil_slave_regs with default parameters.
module tb_axil_slave_regs;

  logic         aclk = 1'b0;
  logic         areset;
  logic [31:0]  awaddr;
  logic         awvalid, awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid, wready;
  logic [1:0]   bresp;
  logic         bvalid, bready;
  logic [31:0]  araddr;
  logic         arvalid, arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid, rready;
  logic [255:0] reg_out;
  logic [255:0] reg_in;
  logic [7:0]   wr_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  int bcnt    = 0;
  int b0;

  always #5 aclk = ~aclk;

  axil_slave_regs dut (
    .aclk           (aclk),
    .areset         (areset),
    .s_axil_awaddr  (awaddr),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .reg_out        (reg_out),
    .reg_in         (reg_in),
    .wr_pulse       (wr_pulse)
  );

  // Count completed B handshakes.
  always @(posedge aclk) begin
    if (!areset && bvalid && bready) bcnt <= bcnt + 1;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    areset = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0; reg_in = '0;

    // Reset state
    tick(); tick();
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_rdata",   rdata,        32'd0);
    areset = 1'b0;
    tick();
    check("post_awready", 32'(awready), 32'd1);
    check("post_wready",  32'(wready),  32'd1);
    check("post_arready", 32'(arready), 32'd1);

    // Same-cycle AW/W to reg 1
    awaddr = 32'h4000_0004; awvalid = 1'b1;
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("t1_c1_bvalid",  32'(bvalid),  32'd0);
    check("t1_c1_awready", 32'(awready), 32'd0);
    check("t1_c1_pulse",   32'(wr_pulse), 32'h00);
    bready = 1'b1;
    tick();
    check("t1_bvalid", 32'(bvalid),     32'd1);
    check("t1_bresp",  32'(bresp),      32'd0);
    check("t1_reg1",   reg_out[63:32],  32'hDEAD_BEEF);
    check("t1_pulse",  32'(wr_pulse),   32'h02);
    tick();
    check("t1_pulse_end",  32'(wr_pulse), 32'h00);
    check("t1_bvalid_end", 32'(bvalid),   32'd0);

    // W first, AW three cycles later, partial strobe to reg 2
    wdata = 32'h1234_5678; wstrb = 4'h3; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("t2_wready_a", 32'(wready), 32'd0);
    tick(); tick();
    check("t2_wready_b", 32'(wready), 32'd0);
    awaddr = 32'h4000_0008; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("t2_wready_c", 32'(wready), 32'd0);
    tick();
    check("t2_bvalid", 32'(bvalid),     32'd1);
    check("t2_reg2",   reg_out[95:64],  32'h0000_5678);
    check("t2_wready", 32'(wready),     32'd1);
    tick();

    // Write to read-only reg 7, then read it
    awaddr = 32'h4000_001C; awvalid = 1'b1;
    wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    check("t3_bvalid", 32'(bvalid),       32'd1);
    check("t3_bresp",  32'(bresp),        32'd2);
    check("t3_reg7",   reg_out[255:224],  32'd0);
    check("t3_pulse",  32'(wr_pulse),     32'h00);
    tick();
    reg_in[255:224] = 32'hCAFE_0001;
    araddr = 32'h4000_001C; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    check("t3_rvalid", 32'(rvalid), 32'd1);
    check("t3_rdata",  rdata,       32'hCAFE_0001);
    check("t3_rresp",  32'(rresp),  32'd0);
    tick();
    check("t3_rvalid_end", 32'(rvalid), 32'd0);
    araddr = 32'h4000_0004; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("t3_rd_reg1", rdata, 32'hDEAD_BEEF);
    tick();

    // Out-of-range reads
    araddr = 32'h4000_0040; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("t4_hi_rvalid", 32'(rvalid), 32'd1);
    check("t4_hi_rdata",  rdata,       32'd0);
    check("t4_hi_rresp",  32'(rresp),  32'd2);
    tick();
    araddr = 32'h3FFF_FFFC; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("t4_lo_rdata", rdata,      32'd0);
    check("t4_lo_rresp", 32'(rresp), 32'd2);
    tick();

    // Back-pressure on B with a second write queued
    bready = 1'b0;
    b0 = bcnt;
    awaddr = 32'h4000_000C; awvalid = 1'b1;
    wdata = 32'h1111_1111; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    check("t5_b1_valid", 32'(bvalid),     32'd1);
    check("t5_reg3",     reg_out[127:96], 32'h1111_1111);
    awaddr = 32'h4000_0010; awvalid = 1'b1;
    wdata = 32'h2222_2222; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("t5_awready_held", 32'(awready), 32'd0);
    check("t5_wready_held",  32'(wready),  32'd0);
    for (int i = 0; i < 3; i++) begin
      check("t5_hold_reg4",   reg_out[159:128], 32'd0);
      check("t5_hold_bvalid", 32'(bvalid),      32'd1);
      tick();
    end
    bready = 1'b1;
    tick();
    check("t5_gap_bvalid", 32'(bvalid),      32'd0);
    check("t5_gap_reg4",   reg_out[159:128], 32'd0);
    tick();
    check("t5_b2_valid", 32'(bvalid),      32'd1);
    check("t5_reg4",     reg_out[159:128], 32'h2222_2222);
    check("t5_pulse",    32'(wr_pulse),    32'h10);
    tick();
    check("t5_bcount", 32'(bcnt - b0), 32'd2);
    tick(); tick();
    check("t5_bcount_stable", 32'(bcnt - b0), 32'd2);

    // Reset while AW is held
    awaddr = 32'h4000_0014; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("t6_aw_held", 32'(awready), 32'd0);
    areset = 1'b1;
    #1;
    check("t6_async_reg1", reg_out[63:32], 32'd0);
    tick();
    areset = 1'b0;
    tick();
    check("t6_awready", 32'(awready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("t6_no_bvalid", 32'(bvalid), 32'd0);
      tick();
    end
    check("t6_reg2", reg_out[95:64],   32'd0);
    check("t6_reg3", reg_out[127:96],  32'd0);
    check("t6_reg4", reg_out[159:128], 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
